// File: rtl/shift_chain_pkg.sv
// Shared definitions for the shift-chain receiver: FSM state encoding and
// default chain geometry (7 cascaded 8-bit shift registers).
package shift_chain_pkg;

    localparam int BITS_PER_REG    = 8;
    localparam int NUM_REGS        = 7;
    localparam int DEF_CHAIN_BITS  = NUM_REGS * BITS_PER_REG;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFTING = 2'd1,
        ST_LATCH    = 2'd2
    } state_e;

endpackage : shift_chain_pkg

// File: rtl/shift_chain_receiver_pin_sync_edge.sv
// pin_sync_edge: multi-flop synchronizer for one asynchronous pin followed by
// a registered rising-edge detector. Flops reset to RST_VAL so that a pin
// idling at its reset level never produces a spurious edge after reset.
module pin_sync_edge #(
    parameter int DEPTH   = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic state_clk,
    input  logic reset,
    input  logic pin_i,
    output logic sync_o,
    output logic rise_o
);

    logic [DEPTH-1:0] sync_q;
    logic             prev_q;
    logic             rise_q;

    // Synchronizer chain, oldest sample at the top bit.
    always_ff @(posedge state_clk) begin
        if (reset) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], pin_i};
        end
    end

    // Registered rising-edge pulse; prev starts equal to the synchronizer
    // reset value so the first cycle after release cannot pulse.
    always_ff @(posedge state_clk) begin
        if (reset) begin
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
        end else begin
            prev_q <= sync_q[DEPTH-1];
            rise_q <= sync_q[DEPTH-1] & ~prev_q;
        end
    end

    assign sync_o = sync_q[DEPTH-1];
    assign rise_o = rise_q;

endmodule : pin_sync_edge

// File: rtl/shift_chain_receiver.sv
// shift_chain_receiver: oversampling receiver for a 74HC595-style shift chain
// (DS / SHCP / STCP / MR_n). Rebuilds the serial frame in shift_reg and
// latches it to frame_data on each storage-clock edge.
// Optional feature: define SHIFT_CHAIN_RX_COUNT_CHECK_EN to enable the sticky
// count_err flag (bit count at latch time differs from CHAIN_BITS).
module shift_chain_receiver
    import shift_chain_pkg::*;
#(
    parameter int CHAIN_BITS  = DEF_CHAIN_BITS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_WIDTH   = 7
) (
    input  logic                  state_clk,
    input  logic                  reset,
    input  logic                  ds_in,
    input  logic                  shcp_in,
    input  logic                  stcp_in,
    input  logic                  mr_n_in,
    output logic [CHAIN_BITS-1:0] frame_data,
    output logic                  frame_valid,
    output logic [CNT_WIDTH-1:0]  shift_count,
    output logic                  busy,
    output logic                  count_err
);

    // Saturating increment for the shift counter.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic ds_sync;
    logic shcp_rise;
    logic stcp_rise;
    logic mr_n_sync;
    logic ds_rise_unused;
    logic shcp_sync_unused;
    logic stcp_sync_unused;
    logic mr_rise_unused;

    pin_sync_edge #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ds (
        .state_clk (state_clk),
        .reset     (reset),
        .pin_i     (ds_in),
        .sync_o    (ds_sync),
        .rise_o    (ds_rise_unused)
    );

    pin_sync_edge #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_shcp (
        .state_clk (state_clk),
        .reset     (reset),
        .pin_i     (shcp_in),
        .sync_o    (shcp_sync_unused),
        .rise_o    (shcp_rise)
    );

    pin_sync_edge #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_stcp (
        .state_clk (state_clk),
        .reset     (reset),
        .pin_i     (stcp_in),
        .sync_o    (stcp_sync_unused),
        .rise_o    (stcp_rise)
    );

    // MR_n idles high, so its synchronizer resets high.
    pin_sync_edge #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_mr (
        .state_clk (state_clk),
        .reset     (reset),
        .pin_i     (mr_n_in),
        .sync_o    (mr_n_sync),
        .rise_o    (mr_rise_unused)
    );

    logic mr_active;
    logic shift_ok;

    assign mr_active = ~mr_n_sync;
    assign shift_ok  = shcp_rise & ~mr_active;

    logic [CHAIN_BITS-1:0] shift_q, shift_d;
    logic [CHAIN_BITS-1:0] frame_q, frame_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    // Datapath next-state: latch sees the pre-shift register, so a
    // coincident SHCP/STCP behaves like the 74HC595.
    always_comb begin
        shift_d = shift_q;
        frame_d = frame_q;
        count_d = count_q;
        if (stcp_rise) begin
            frame_d = shift_q;
        end
        if (mr_active) begin
            shift_d = '0;
        end else if (shcp_rise) begin
            shift_d = {shift_q[CHAIN_BITS-2:0], ds_sync};
        end
        if (stcp_rise || mr_active) begin
            count_d = '0;
        end else if (shcp_rise) begin
            count_d = sat_inc(count_q);
        end
    end

    // Datapath registers.
    always_ff @(posedge state_clk) begin
        if (reset) begin
            shift_q <= '0;
            frame_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            frame_q <= frame_d;
            count_q <= count_d;
        end
    end

`ifdef SHIFT_CHAIN_RX_COUNT_CHECK_EN
    logic err_q, err_d;

    // Sticky flag for a latch that did not follow exactly CHAIN_BITS shifts.
    always_comb begin
        err_d = err_q;
        if (stcp_rise && (count_q != CNT_WIDTH'(CHAIN_BITS))) begin
            err_d = 1'b1;
        end
    end

    // Bit-count error register, cleared only by reset.
    always_ff @(posedge state_clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign count_err = err_q;
`else
    assign count_err = 1'b0;
`endif

    state_e state_q, state_d;

    // FSM state register.
    always_ff @(posedge state_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a storage edge always wins so every latch is
    // reported through LATCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (stcp_rise) begin
                    state_d = ST_LATCH;
                end else if (shift_ok) begin
                    state_d = ST_SHIFTING;
                end
            end
            ST_SHIFTING: begin
                if (stcp_rise) begin
                    state_d = ST_LATCH;
                end else if (mr_active) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LATCH: begin
                if (stcp_rise) begin
                    state_d = ST_LATCH;
                end else if (shift_ok) begin
                    state_d = ST_SHIFTING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy        = (state_q == ST_SHIFTING);
        frame_valid = (state_q == ST_LATCH);
    end

    assign frame_data  = frame_q;
    assign shift_count = count_q;

endmodule : shift_chain_receiver
